// File: rtl/aes_ks_pkg.sv
// Shared definitions for the iterative AES-128 key schedule: FSM encoding,
// round constants and GF(2^8) helpers used by the S-box.
package aes_ks_pkg;

    localparam int NR     = 10;
    localparam int WORD_W = 32;
    localparam int KEY_W  = 128;
    localparam int RND_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_OUT    = 2'd2
    } ks_state_t;

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

endpackage

// File: rtl/aes_ks_step_128.sv
// One AES-128 key-expansion step, forward (rnd -> rnd+1) or inverse
// (rnd -> rnd-1), sharing a single four-byte SubWord between directions.
module aes_ks_step_128
    import aes_ks_pkg::*;
(
    input  logic [KEY_W-1:0]  rk_in,
    input  logic [RND_W-1:0]  rnd,
    input  logic              inv,
    output logic [KEY_W-1:0]  rk_out
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] sub_in, rot_word, sub_word, g_word;
    logic [WORD_W-1:0] n0, n1, n2, n3;
    logic [RND_W-1:0]  rc_idx;

    assign w0 = rk_in[127:96];
    assign w1 = rk_in[95:64];
    assign w2 = rk_in[63:32];
    assign w3 = rk_in[31:0];

    // The inverse step needs SubWord of the already-recovered w3 (= w3^w2).
    assign sub_in   = inv ? (w3 ^ w2) : w3;
    assign rot_word = {sub_in[23:0], sub_in[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox_lut u_sbox (
                .din  (rot_word[gi*8 +: 8]),
                .dec  (1'b0),
                .dout (sub_word[gi*8 +: 8])
            );
        end
    endgenerate

    assign rc_idx = inv ? (rnd - 4'd1) : rnd;
    assign g_word = sub_word ^ {rcon(rc_idx), 24'h000000};

    always_comb begin
        if (inv) begin
            n3 = w3 ^ w2;
            n2 = w2 ^ w1;
            n1 = w1 ^ w0;
            n0 = w0 ^ g_word;
        end else begin
            n0 = w0 ^ g_word;
            n1 = w1 ^ n0;
            n2 = w2 ^ n1;
            n3 = w3 ^ n2;
        end
    end

    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox_lut.sv
// Byte S-box (dec=0) / inverse S-box (dec=1); a pure function of its inputs,
// flattened into LUTs by synthesis.
module aes_sbox_lut
    import aes_ks_pkg::*;
(
    input  logic [7:0] din,
    input  logic       dec,
    output logic [7:0] dout
);

    logic [7:0] inv_aff;

    always_comb begin
        inv_aff = rotl8(din, 1) ^ rotl8(din, 3) ^ rotl8(din, 6) ^ 8'h05;
        if (dec) begin
            dout = gf_inv(inv_aff);
        end else begin
            dout = gf_inv(din);
            dout = dout ^ rotl8(dout, 1) ^ rotl8(dout, 2) ^ rotl8(dout, 3)
                 ^ rotl8(dout, 4) ^ 8'h63;
        end
    end

endmodule

// File: rtl/aes_ks_iter_128.sv
// Iterative AES-128 key schedule streaming rk0..rk10 (forward) or rk10..rk0
// (reverse, after a 10-cycle forward expansion) one key per handshake.
module aes_ks_iter_128
    import aes_ks_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_valid,
    input  logic              dec,
    output logic              key_ready,
    output logic [KEY_W-1:0]  rk_out,
    output logic [RND_W-1:0]  rk_round,
    output logic              rk_valid,
    input  logic              rk_next,
    output logic              busy
);

    ks_state_t         state_reg, state_next;
    logic [KEY_W-1:0]  rk_reg, rk_next_val;
    logic [RND_W-1:0]  rnd_reg, rnd_next;
    logic              dir_reg, dir_next;

    logic [KEY_W-1:0]  step_out;
    logic              step_inv;

    // EXPAND always walks forward; OUT walks in the captured direction.
    assign step_inv = (state_reg == ST_OUT) && dir_reg;

    aes_ks_step_128 u_step (
        .rk_in  (rk_reg),
        .rnd    (rnd_reg),
        .inv    (step_inv),
        .rk_out (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            rk_reg    <= '0;
            rnd_reg   <= '0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rk_reg    <= rk_next_val;
            rnd_reg   <= rnd_next;
            dir_reg   <= dir_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rk_next_val = rk_reg;
        rnd_next    = rnd_reg;
        dir_next    = dir_reg;
        case (state_reg)
            ST_IDLE: begin
                if (key_valid) begin
                    rk_next_val = key_in;
                    rnd_next    = '0;
                    dir_next    = dec;
                    state_next  = dec ? ST_EXPAND : ST_OUT;
                end
            end
            ST_EXPAND: begin
                rk_next_val = step_out;
                rnd_next    = rnd_reg + 4'd1;
                if (rnd_reg == RND_W'(NR - 1)) state_next = ST_OUT;
            end
            ST_OUT: begin
                if (rk_next) begin
                    if ((!dir_reg && rnd_reg == RND_W'(NR)) ||
                        ( dir_reg && rnd_reg == '0)) begin
                        state_next = ST_IDLE;
                    end else begin
                        rk_next_val = step_out;
                        rnd_next    = dir_reg ? (rnd_reg - 4'd1) : (rnd_reg + 4'd1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        key_ready = (state_reg == ST_IDLE);
        busy      = (state_reg == ST_EXPAND) || (state_reg == ST_OUT);
        rk_valid  = (state_reg == ST_OUT);
        rk_out    = rk_valid ? rk_reg : '0;
        rk_round  = rk_valid ? rnd_reg : '0;
    end

endmodule

// File: tb/tb_aes_ks_iter_128.sv
// Self-checking bench for aes_ks_iter_128: FIPS-197 vector table, handshake
// timing, random keys/gaps against a word-array key-expansion model.
module tb_aes_ks_iter_128;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         dec;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_next;
    logic         busy;

    int vec_count = 0;
    int err_count = 0;

    logic [7:0]   sbox_t   [256];
    logic [127:0] model_rk [11];
    logic [127:0] cap_rk   [11];
    logic [127:0] first_out, last_out;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic         dec;
        logic [127:0] first;
        logic [127:0] last;
        int           mid_idx;
        logic [127:0] mid;
    } vec_t;

    vec_t vecs [3];

    aes_ks_iter_128 dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .dec       (dec),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_next   (rk_next),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] m_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] aa, bb, p;
        aa = a; bb = b; p = 8'h00;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = m_xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: brute-force inverse then bitwise affine map.
    task automatic build_sbox();
        logic [7:0] c, s, iv;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int y = 1; y < 256 && x != 0; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = m_xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " key_ready"}, 128'(key_ready), 128'(1));
        chk({nm, " busy"},      128'(busy),      128'(0));
        chk({nm, " rk_valid"},  128'(rk_valid),  128'(0));
        chk({nm, " rk_out"},    rk_out,          128'(0));
        chk({nm, " rk_round"},  128'(rk_round),  128'(0));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!key_ready && n < 50) begin tick(); n++; end
        if (!key_ready) chk("wait key_ready timeout", 128'(key_ready), 128'(1));
    endtask

    // Accept a key and drain the stream; max_gap>0 inserts random rk_next gaps,
    // poke injects rk_next in EXPAND and a key_valid pulse while busy.
    task automatic run_stream(input logic [127:0] key, input logic d,
                              input int max_gap, input logic poke);
        int idx, g;
        model_expand(key);
        wait_ready();
        key_in = key; dec = d; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        dec = ~d;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        if (d) begin
            for (int i = 0; i < 10; i++) begin
                chk("expand busy", 128'(busy), 128'(1));
                chk("expand rk_valid", 128'(rk_valid), 128'(0));
                rk_next   = poke && (i == 3);
                key_valid = poke && (i == 5);
                tick();
            end
            rk_next = 1'b0; key_valid = 1'b0;
        end
        for (int k = 0; k < 11; k++) begin
            idx = d ? 10 - k : k;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int j = 0; j < g; j++) begin
                rk_next = 1'b0;
                chk("hold rk_out", rk_out, model_rk[idx]);
                tick();
            end
            chk("rk_valid", 128'(rk_valid), 128'(1));
            chk("rk_out", rk_out, model_rk[idx]);
            chk("rk_round", 128'(rk_round), 128'(idx));
            cap_rk[rk_round] = rk_out;
            if (k == 0) first_out = rk_out;
            if (k == 10) last_out = rk_out;
            key_valid = poke && (k == 2);
            rk_next = 1'b1;
            tick();
            key_valid = 1'b0;
        end
        rk_next = 1'b0;
        chk_idle_outputs("end of stream");
        $display("stream key=%h dec=%0d gap=%0d poke=%0d done", key, d, max_gap, poke);
    endtask

    initial begin
        logic [127:0] k;
        rst = 1'b1; key_in = '0; key_valid = 1'b0; dec = 1'b0; rk_next = 1'b0;
        build_sbox();
        #2;
        chk_idle_outputs("reset");
        tick();
        rst = 1'b0;

        vecs[0] = '{"fips fwd", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0,
                    128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    1, 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{"fips rev", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    128'h2b7e151628aed2a6abf7158809cf4f3c,
                    9, 128'hac7766f319fadc2128d12941575c006e};
        vecs[2] = '{"c1 rev", 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                    128'h13111d7fe3944a17f307a78b4d2b30c5,
                    128'h000102030405060708090a0b0c0d0e0f,
                    10, 128'h13111d7fe3944a17f307a78b4d2b30c5};

        for (int v = 0; v < 3; v++) begin
            run_stream(vecs[v].key, vecs[v].dec, 0, 1'b0);
            chk({vecs[v].name, " first"}, first_out, vecs[v].first);
            chk({vecs[v].name, " last"},  last_out,  vecs[v].last);
            chk({vecs[v].name, " mid"},   cap_rk[vecs[v].mid_idx], vecs[v].mid);
            $display("vector %s applied", vecs[v].name);
        end

        // rk_next in IDLE is ignored
        rk_next = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle rk_next rk_valid", 128'(rk_valid), 128'(0));
            chk("idle rk_next key_ready", 128'(key_ready), 128'(1));
        end
        rk_next = 1'b0;

        // Reset at the 5th reverse-mode output, then a fresh reverse stream
        k = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k);
        key_in = k; dec = 1'b1; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 4; i++) begin
            chk("pre-reset rk_out", rk_out, model_rk[10-i]);
            rk_next = 1'b1;
            tick();
        end
        chk("5th output", rk_out, model_rk[6]);
        #2 rst = 1'b1;
        #1 chk_idle_outputs("async reset");
        rk_next = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk_idle_outputs("after reset");
        $display("reset mid-stream sequence done");
        k = {$urandom, $urandom, $urandom, $urandom};
        run_stream(k, 1'b1, 0, 1'b0);

        // Random keys, random consumer gaps, pokes while busy
        for (int r = 0; r < 8; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run_stream(k, 1'($urandom_range(0, 1)), 3, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
